// File: rtl/acondicionador_entradas.sv
// Input conditioning for the SECDED codec: per-bit 2-flop synchronizer plus
// debounce counter on 4 data and 4 error-injection switches.
module acondicionador_entradas #(
    parameter int N_ESTABLE  = 270000,
    parameter int ANCHO_CONT = $clog2(N_ESTABLE + 1)
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic [3:0] sw_dato,
    input  logic [3:0] sw_error,
    output logic [3:0] dato_entrada,
    output logic [3:0] dato_error,
    output logic       dato_nuevo,
    output logic       estable
);

    localparam logic [ANCHO_CONT-1:0] CNT_FIN = ANCHO_CONT'(N_ESTABLE - 1);

    logic [7:0]            pin;
    logic [7:0]            s1;
    logic [7:0]            s2;
    logic [7:0]            q;
    logic [7:0]            voltea;
    logic [7:0]            asentado;
    logic [ANCHO_CONT-1:0] cnt [8];
    logic                  arrancado;

    assign pin = {sw_error, sw_dato};

    always_comb begin
        voltea   = '0;
        asentado = '0;
        for (int i = 0; i < 8; i++) begin
            voltea[i]   = (s2[i] != q[i]) && (cnt[i] == CNT_FIN);
            asentado[i] = (s2[i] == q[i]) && (cnt[i] == '0);
        end
    end

    // arrancado holds estable low on the first edge after reset, while the
    // synchronizers still carry reset values rather than sampled pins.
    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            s1         <= '0;
            s2         <= '0;
            q          <= '0;
            dato_nuevo <= 1'b0;
            estable    <= 1'b0;
            arrancado  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1         <= pin;
            s2         <= s1;
            dato_nuevo <= |voltea;
            estable    <= arrancado & (&asentado);
            arrancado  <= 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (s2[i] == q[i]) begin
                    cnt[i] <= '0;
                end else if (voltea[i]) begin
                    q[i]   <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign dato_entrada = q[3:0];
    assign dato_error   = q[7:4];

endmodule

// File: tb/tb_acondicionador_entradas.sv
// Directed bench for acondicionador_entradas: N_ESTABLE=4 main instance plus
// an N_ESTABLE=1 instance sharing the same pins for the minimum-latency case.
module tb_acondicionador_entradas;

    logic       reloj = 1'b0;
    logic       reset;
    logic [3:0] sw_dato;
    logic [3:0] sw_error;
    logic [3:0] dato_entrada, dato_error;
    logic       dato_nuevo, estable;
    logic [3:0] dato_entrada_1, dato_error_1;
    logic       dato_nuevo_1, estable_1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 reloj = ~reloj;

    acondicionador_entradas #(.N_ESTABLE(4)) dut (
        .reloj        (reloj),
        .reset        (reset),
        .sw_dato      (sw_dato),
        .sw_error     (sw_error),
        .dato_entrada (dato_entrada),
        .dato_error   (dato_error),
        .dato_nuevo   (dato_nuevo),
        .estable      (estable)
    );

    acondicionador_entradas #(.N_ESTABLE(1)) dut1 (
        .reloj        (reloj),
        .reset        (reset),
        .sw_dato      (sw_dato),
        .sw_error     (sw_error),
        .dato_entrada (dato_entrada_1),
        .dato_error   (dato_error_1),
        .dato_nuevo   (dato_nuevo_1),
        .estable      (estable_1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Each call advances exactly one rising edge; sampling happens on the falling edge.
    task automatic ciclo();
        @(negedge reloj);
    endtask

    task automatic reposo(input int n);
        for (int i = 0; i < n; i++) ciclo();
    endtask

    initial begin
        logic [4:0] rebote;
        rebote   = 5'b01101;
        reset    = 1'b1;
        sw_dato  = 4'h0;
        sw_error = 4'h0;

        // Reset values
        reposo(3);
        chk("rst_dato_entrada", dato_entrada, 8'h0);
        chk("rst_dato_error",   dato_error,   8'h0);
        chk("rst_dato_nuevo",   dato_nuevo,   8'h0);
        chk("rst_estable",      estable,      8'h0);
        reset = 1'b0;
        ciclo();
        chk("rel1_estable", estable, 8'h0);
        ciclo();
        chk("rel2_estable", estable, 8'h1);
        for (int k = 0; k < 4; k++) begin
            ciclo();
            chk("rel_dato_nuevo", dato_nuevo, 8'h0);
            chk("rel_estable",    estable,    8'h1);
        end

        // Clean data change, edges E0..E7
        sw_dato = 4'b1011;
        for (int k = 0; k <= 7; k++) begin
            ciclo();
            chk("limpio_dato_entrada", dato_entrada, (k >= 5) ? 8'hB : 8'h0);
            chk("limpio_dato_nuevo",   dato_nuevo,   (k == 5) ? 8'h1 : 8'h0);
            chk("limpio_estable",      estable,      (k >= 2 && k <= 5) ? 8'h0 : 8'h1);
            chk("limpio_dato_error",   dato_error,   8'h0);
            chk("n1_dato_entrada",     dato_entrada_1, (k >= 2) ? 8'hB : 8'h0);
            chk("n1_dato_nuevo",       dato_nuevo_1,   (k == 2) ? 8'h1 : 8'h0);
            chk("n1_estable",          estable_1,      (k == 2) ? 8'h0 : 8'h1);
            chk("n1_dato_error",       dato_error_1,   8'h0);
        end

        // Glitch rejection: 3-cycle pulse peaks at cnt=3 and is then cleared
        sw_error = 4'b0100;
        reposo(3);
        sw_error = 4'b0000;
        for (int k = 0; k < 7; k++) begin
            ciclo();
            chk("glitch_dato_error", dato_error, 8'h0);
            chk("glitch_dato_nuevo", dato_nuevo, 8'h0);
        end
        chk("glitch_estable", estable, 8'h1);

        sw_dato = 4'h0;
        reposo(10);
        chk("vuelta0_dato_entrada", dato_entrada, 8'h0);
        chk("vuelta0_estable",      estable,      8'h1);

        // Bounce 1,0,1,1,0 then hold 1: last 0->1 captured at E5, flip at E10
        for (int k = 0; k <= 12; k++) begin
            sw_dato[0] = (k < 5) ? rebote[k] : 1'b1;
            ciclo();
            chk("rebote_dato_entrada", dato_entrada, (k >= 10) ? 8'h1 : 8'h0);
            chk("rebote_dato_nuevo",   dato_nuevo,   (k == 10) ? 8'h1 : 8'h0);
        end

        sw_dato = 4'h0;
        reposo(10);
        chk("vuelta1_dato_entrada", dato_entrada, 8'h0);

        // Simultaneous change on both switch banks
        sw_dato  = 4'hF;
        sw_error = 4'h3;
        for (int k = 0; k <= 7; k++) begin
            ciclo();
            chk("simul_dato_entrada", dato_entrada, (k >= 5) ? 8'hF : 8'h0);
            chk("simul_dato_error",   dato_error,   (k >= 5) ? 8'h3 : 8'h0);
            chk("simul_dato_nuevo",   dato_nuevo,   (k == 5) ? 8'h1 : 8'h0);
        end

        sw_dato  = 4'h0;
        sw_error = 4'h0;
        reposo(10);
        chk("vuelta2_dato_entrada", dato_entrada, 8'h0);
        chk("vuelta2_dato_error",   dato_error,   8'h0);

        // Reset mid-debounce: cnt=3 after E4
        sw_dato = 4'h6;
        reposo(5);
        chk("prerst_dato_entrada", dato_entrada, 8'h0);
        reset = 1'b1;
        #1;
        chk("midrst_dato_entrada", dato_entrada, 8'h0);
        chk("midrst_dato_nuevo",   dato_nuevo,   8'h0);
        chk("midrst_estable",      estable,      8'h0);
        ciclo();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            ciclo();
            chk("postrst_dato_entrada", dato_entrada, (k >= 6) ? 8'h6 : 8'h0);
            chk("postrst_dato_nuevo",   dato_nuevo,   (k == 6) ? 8'h1 : 8'h0);
            if (k == 1) chk("postrst_estable", estable, 8'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
